// File: rtl/lieat_exu_wbck_sb.sv
// Writeback sink and scoreboard: per-register outstanding-write counters, hazard flags, regfile write port.
// Optional same-cycle operand bypass is compiled in with LIEAT_WBCK_BYPASS_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX
`define REG_IDX 5
`endif

module lieat_exu_wbck_sb #(
  parameter int CNT_W = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic                issue_rd_en,
  input  logic [`REG_IDX-1:0] issue_rd,
  input  logic [`REG_IDX-1:0] issue_rs1,
  input  logic [`REG_IDX-1:0] issue_rs2,
  output logic                issue_ready,
  input  logic                wbck_i_valid,
  input  logic [4:0]          wbck_i_op,
  input  logic [`XLEN-1:0]    wbck_i_pc,
  input  logic                wbck_i_en,
  input  logic [`REG_IDX-1:0] wbck_i_rd,
  input  logic [`XLEN-1:0]    wbck_i_data,
  input  logic                wbck_i_ebreak,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                fwd_rs1_vld,
  output logic                fwd_rs2_vld,
  output logic [`XLEN-1:0]    fwd_rs1_data,
  output logic [`XLEN-1:0]    fwd_rs2_data,
  output logic                rf_wen,
  output logic [`REG_IDX-1:0] rf_waddr,
  output logic [`XLEN-1:0]    rf_wdata,
  output logic [63:0]         instret,
  output logic                halted,
  output logic                sb_underflow
);

  localparam int NREG = 1 << `REG_IDX;

  // Entry 0 is never written, so x0 reads as an idle register.
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [63:0]      instret_q, instret_d;
  logic             halted_q, halted_d;
  logic             uflow_q, uflow_d;

  logic issue_fire, wb_fire, inc_en, same_reg;
  logic rs1_raw_busy, rs2_raw_busy;
  logic unused_wbck_meta;

  assign unused_wbck_meta = ^{wbck_i_op, wbck_i_pc};

  assign wb_fire     = wbck_i_valid & wbck_i_en & (wbck_i_rd != '0);
  assign same_reg    = wb_fire & (wbck_i_rd == issue_rd);
  assign issue_ready = ~halted_q & ~((cnt_q[issue_rd] == '1) & issue_rd_en & ~same_reg);
  assign issue_fire  = issue_valid & issue_ready;
  assign inc_en      = issue_fire & issue_rd_en & (issue_rd != '0);

  always_comb begin
    cnt_d[0] = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_en && issue_rd == `REG_IDX'(r)) begin
        if (!(wb_fire && wbck_i_rd == `REG_IDX'(r)))
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (wb_fire && wbck_i_rd == `REG_IDX'(r) && cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    instret_d = instret_q;
    halted_d  = halted_q;
    uflow_d   = uflow_q;
    if (wbck_i_valid)                  instret_d = instret_q + 64'd1;
    if (wbck_i_valid && wbck_i_ebreak) halted_d  = 1'b1;
    if (wb_fire && cnt_q[wbck_i_rd] == '0) uflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      uflow_q   <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      instret_q <= instret_d;
      halted_q  <= halted_d;
      uflow_q   <= uflow_d;
    end
  end

  assign rs1_raw_busy = (issue_rs1 != '0) & (cnt_q[issue_rs1] != '0);
  assign rs2_raw_busy = (issue_rs2 != '0) & (cnt_q[issue_rs2] != '0);

`ifdef LIEAT_WBCK_BYPASS_EN
  logic hit1, hit2;
  // Forward only when this writeback retires the last outstanding write.
  assign hit1 = wb_fire & (wbck_i_rd == issue_rs1) & (cnt_q[issue_rs1] == CNT_W'(1));
  assign hit2 = wb_fire & (wbck_i_rd == issue_rs2) & (cnt_q[issue_rs2] == CNT_W'(1));
  assign rs1_busy     = rs1_raw_busy & ~hit1;
  assign rs2_busy     = rs2_raw_busy & ~hit2;
  assign fwd_rs1_vld  = hit1;
  assign fwd_rs2_vld  = hit2;
  assign fwd_rs1_data = hit1 ? wbck_i_data : '0;
  assign fwd_rs2_data = hit2 ? wbck_i_data : '0;
`else
  assign rs1_busy     = rs1_raw_busy;
  assign rs2_busy     = rs2_raw_busy;
  assign fwd_rs1_vld  = 1'b0;
  assign fwd_rs2_vld  = 1'b0;
  assign fwd_rs1_data = '0;
  assign fwd_rs2_data = '0;
`endif

  assign rf_wen       = wb_fire;
  assign rf_waddr     = wbck_i_rd;
  assign rf_wdata     = wbck_i_data;
  assign instret      = instret_q;
  assign halted       = halted_q;
  assign sb_underflow = uflow_q;

endmodule
